ghostbus_host: RTL
==================

GHOSTBUS_HOST -- requirements
Module: ghostbus_host

Interface
REQ-001 Parameter GB_AW, default 24, ghostbus address width.
REQ-002 Parameter GB_DW, default 32, ghostbus data width.
REQ-003 Parameter RD_LAT, default 1, cycles from the read-strobe cycle to valid gb_rdata; legal range 1..15.
REQ-004 gb_clk  input  1  single clock; all logic on its rising edge.
REQ-005 gb_rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  request accepted when high with req_valid.
REQ-008 req_we  input  1  1=write, 0=read.
REQ-009 req_addr  input  GB_AW  target address.
REQ-010 req_wdata  input  GB_DW  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 rsp_we  output  1  echo of the request type.
REQ-014 rsp_rdata  output  GB_DW  read data; 0 for writes.
REQ-015 gb_addr  output  GB_AW  bus address.
REQ-016 gb_wdata  output  GB_DW  bus write data.
REQ-017 gb_wen  output  1  one-cycle write strobe.
REQ-018 gb_rstb  output  1  one-cycle read strobe.
REQ-019 gb_rdata  input  GB_DW  bus read data from responder.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states are IDLE, STROBE, RWAIT, RESP.
REQ-022 req_ready is high only in IDLE, combinationally from state.
REQ-023 On accept (edge E), the block registers addr/wdata/we onto gb_addr/gb_wdata/rsp_we and enters STROBE.
REQ-024 In STROBE (cycle E+1), exactly one of gb_wen (write) or gb_rstb (read) is high, registered, for exactly one cycle.
REQ-025 Write: STROBE -> RESP; rsp_valid rises at cycle E+2 with rsp_rdata=0.
REQ-026 Read: STROBE -> RWAIT; a down-counter loaded with RD_LAT-1 counts in RWAIT; gb_rdata is captured into rsp_rdata at the edge ending the RD_LAT-th cycle after the strobe cycle; then RESP.
REQ-027 Read with RD_LAT=1: rsp_valid rises at cycle E+3.
REQ-028 RESP holds rsp_valid, rsp_we and rsp_rdata stable until rsp_valid and rsp_ready are both high; then -> IDLE.
REQ-029 No same-cycle accept on response handshake: req_ready rises the cycle after the response is consumed.
REQ-030 gb_addr and gb_wdata hold their last values between transactions; they change only on accept.
REQ-031 gb_wen and gb_rstb are never high simultaneously and never high outside STROBE.
REQ-032 gb_rdata is ignored in all cycles except the capture edge.
REQ-033 Counter width is 4 bits; RD_LAT outside 1..15 is a synthesis-time error.

Reset
REQ-034 While gb_rst_n is low: state IDLE; req_ready=1; rsp_valid, rsp_we, gb_wen, gb_rstb, busy=0; gb_addr, gb_wdata, rsp_rdata=0; counter=0.
REQ-035 Assertion mid-transaction takes effect immediately (asynchronously), drops any strobe, and discards the pending response without a bus retry.
REQ-036 Reset deassertion is synchronized externally; the first accept is legal on the first edge after release.

Structure
REQ-037 State encodings and RD_LAT limits are localparams in shared package ghostbus_host_pkg.
REQ-038 The block is a single module with no sub-modules; counter and FSM are in-line.

Verification
REQ-039 Write 0xDEADBEEF to 0x000010 -> gb_wen high exactly one cycle with gb_addr=0x000010, gb_wdata=0xDEADBEEF; rsp_valid at E+2, rsp_we=1, rsp_rdata=0.
REQ-040 Read 0x000010 with RD_LAT=1, responder returns 0xDEADBEEF -> gb_rstb one cycle; rsp_valid at E+3 with rsp_rdata=0xDEADBEEF, rsp_we=0.
REQ-041 RD_LAT=4 read, responder returns 0x12345678 only on the 4th post-strobe cycle and 0xFFFFFFFF otherwise -> rsp_rdata=0x12345678.
REQ-042 rsp_ready held low 10 cycles -> rsp_valid/rsp_rdata stable, req_ready low throughout, req_valid ignored; 1 cycle after release, req_ready=1.
REQ-043 gb_rst_n pulsed low during the read strobe cycle -> gb_rstb falls within the same cycle, no rsp_valid ever issued, all outputs at reset values.
REQ-044 100 back-to-back random read/write requests against a 64-word memory model -> every read returns the last value written; gb_wen and gb_rstb are never high together.

Source files
------------

// File: rtl/ghostbus_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ghostbus_host_pkg
// Description : Shared constants for the ghostbus host controller: FSM state
//               encodings, read-latency counter width and legal RD_LAT range.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ghostbus_host_pkg;

  // FSM state encoding
  localparam int unsigned c_st_w = 2;
  localparam logic [c_st_w-1:0] c_st_idle   = 2'd0;
  localparam logic [c_st_w-1:0] c_st_strobe = 2'd1;
  localparam logic [c_st_w-1:0] c_st_rwait  = 2'd2;
  localparam logic [c_st_w-1:0] c_st_resp   = 2'd3;

  // Read-latency down-counter
  localparam int unsigned c_cnt_w      = 4;
  localparam int unsigned c_rd_lat_min = 1;
  localparam int unsigned c_rd_lat_max = 15;

endpackage : ghostbus_host_pkg
`default_nettype wire

// File: rtl/ghostbus_host.sv
`default_nettype none
// ============================================================================
// Module      : ghostbus_host
// Description : Single-outstanding request/response host for the ghostbus.
//               An accepted request is issued as a one-cycle write or read
//               strobe; reads wait RD_LAT cycles and capture gb_rdata once.
//               The response is held until consumed.
// Ports       : gb_clk, gb_rst_n              - clock, async active-low reset
//               req_valid/ready/we/addr/wdata - request channel
//               rsp_valid/ready/we/rdata      - response channel
//               gb_addr/wdata/wen/rstb/rdata  - ghostbus responder side
//               busy                          - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module ghostbus_host
  import ghostbus_host_pkg::*;
#(
  parameter int unsigned GB_AW  = 24,
  parameter int unsigned GB_DW  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             gb_clk,
  input  logic             gb_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [GB_AW-1:0] req_addr,
  input  logic [GB_DW-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_we,
  output logic [GB_DW-1:0] rsp_rdata,
  output logic [GB_AW-1:0] gb_addr,
  output logic [GB_DW-1:0] gb_wdata,
  output logic             gb_wen,
  output logic             gb_rstb,
  input  logic [GB_DW-1:0] gb_rdata,
  output logic             busy
);

  // Out-of-range read latency cannot be represented by the 4-bit counter.
  generate
    if ((RD_LAT < c_rd_lat_min) || (RD_LAT > c_rd_lat_max)) begin : g_rd_lat_bad
      $error("ghostbus_host: RD_LAT must be within 1..15");
    end
  endgenerate

  // Counter preload: RWAIT lasts RD_LAT cycles, counting RD_LAT-1 down to 0.
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(RD_LAT - 1);

  logic [c_st_w-1:0]  r_state;
  logic [c_st_w-1:0]  w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_gb_wen;
  logic               r_gb_rstb;
  logic               r_rsp_we;
  logic [GB_AW-1:0]   r_gb_addr;
  logic [GB_DW-1:0]   r_gb_wdata;
  logic [GB_DW-1:0]   r_rsp_rdata;
  logic               w_accept;
  logic               w_cnt_zero;

  assign w_accept   = req_valid && req_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // State register
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_state_nxt = c_st_strobe;
      c_st_strobe: w_state_nxt = r_rsp_we ? c_st_resp : c_st_rwait;
      c_st_rwait:  if (w_cnt_zero) w_state_nxt = c_st_resp;
      c_st_resp:   if (rsp_ready) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // State-decoded outputs. The response handshake only moves to IDLE, so
  // req_ready cannot rise in the same cycle the response is consumed.
  always_comb begin
    req_ready = (r_state == c_st_idle);
    busy      = (r_state != c_st_idle);
    rsp_valid = (r_state == c_st_resp);
  end

  // Datapath: request capture, strobes, latency counter, read capture
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_gb_wen    <= 1'b0;
      r_gb_rstb   <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_gb_addr   <= '0;
      r_gb_wdata  <= '0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
    end else begin
      // Strobes are set only by the accept edge, so they live for exactly
      // the STROBE cycle and are mutually exclusive.
      r_gb_wen  <= w_accept && req_we;
      r_gb_rstb <= w_accept && !req_we;

      if (w_accept) begin
        r_gb_addr   <= req_addr;
        r_gb_wdata  <= req_wdata;
        r_rsp_we    <= req_we;
        r_rsp_rdata <= '0;
      end

      if (r_state == c_st_strobe) begin
        r_cnt <= c_cnt_load;
      end else if ((r_state == c_st_rwait) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Single sampling point for gb_rdata.
      if ((r_state == c_st_rwait) && w_cnt_zero) begin
        r_rsp_rdata <= gb_rdata;
      end
    end
  end

  assign gb_wen    = r_gb_wen;
  assign gb_rstb   = r_gb_rstb;
  assign gb_addr   = r_gb_addr;
  assign gb_wdata  = r_gb_wdata;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;

endmodule : ghostbus_host
`default_nettype wire
